// File: rtl/uart_tx_arbiter_if.sv
// Requester / uart_tx side bundle for uart_tx_arbiter.
// master: requesters and the uart_tx consumer; slave: the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_lock,
    input  req_ready, tx_start, tx_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_lock,
    output req_ready, tx_start, tx_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding a uart_tx, pacing
// successive starts by one full frame (11 bit times) so the transmitter
// is never re-triggered mid-frame.
// Optional feature macro: UART_ARB_LOCK_EN -- when defined, a requester
// accepted with req_lock=1 keeps exclusive grant until it drops req_lock.
module uart_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200
) (
  input logic             Clock,
  input logic             Reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int FRAME_CYCLES = BAUD_DIVISOR * 11;
  localparam int CNT_W        = ($clog2(FRAME_CYCLES) > 16) ? $clog2(FRAME_CYCLES) : 16;
  localparam int IDW          = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               tx_start_reg;
  logic [7:0]         tx_data_reg;
  logic [IDW-1:0]     grant_id_reg;
  logic               busy_reg;
  logic               lock_reg;

  logic [7:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] ready_next;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic               accept;

  // Split the packed byte bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  assign grant_onehot = NUM_REQ'(1) << grant_id_reg;

`ifdef UART_ARB_LOCK_EN
  // Eligibility: a held lock narrows the field to the lock owner only.
  always_comb begin
    eligible = bus.req_valid;
    if (lock_reg && bus.req_lock[grant_id_reg]) begin
      eligible = bus.req_valid & grant_onehot;
    end
  end
`else
  // Eligibility: every valid requester; req_lock is deliberately ignored.
  logic unused_lock;
  assign unused_lock = ^{bus.req_lock, lock_reg, grant_onehot};

  always_comb begin
    eligible = bus.req_valid;
  end
`endif

  // Round-robin search starting just after the last grant; iterating from
  // the farthest offset down lets the nearest eligible requester win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (eligible[(int'(grant_id_reg) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(grant_id_reg) + k) % NUM_REQ);
      end
    end
  end

  // Acceptance strobe is combinational so the transfer happens on this edge.
  always_comb begin
    accept     = Reset_n && (state_reg == IDLE) && win_found;
    ready_next = '0;
    if (accept) begin
      ready_next = NUM_REQ'(1) << win_idx;
    end
  end

  assign bus.req_ready = ready_next;
  assign bus.tx_start  = tx_start_reg;
  assign bus.tx_data   = tx_data_reg;
  assign bus.grant_id  = grant_id_reg;
  assign bus.busy      = busy_reg;

  // Arbitration / pacing FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      grant_id_reg <= IDW'(NUM_REQ - 1);
      busy_reg     <= 1'b0;
      lock_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef UART_ARB_LOCK_EN
          if (lock_reg && !bus.req_lock[grant_id_reg]) begin
            lock_reg <= 1'b0;
          end
`endif
          if (win_found) begin
            tx_data_reg  <= req_byte[win_idx];
            grant_id_reg <= win_idx;
            tx_start_reg <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= START;
`ifdef UART_ARB_LOCK_EN
            lock_reg     <= bus.req_lock[win_idx];
`endif
          end
        end
        START: begin
          tx_start_reg <= 1'b0;
          cnt_reg      <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == CNT_W'(FRAME_CYCLES - 1)) begin
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          tx_start_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run, all
// checked cycle by cycle against a countdown/scan reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int CLK_HZ      = 1000;
  localparam int BAUD        = 100;
  localparam int FRAME       = (CLK_HZ / BAUD) * 11;
  localparam int BUSY_CYCLES = FRAME + 1;
  localparam int SPACING     = FRAME + 2;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  always #5 Clock = ~Clock;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  // Stimulus state (requesters)
  logic       rst_n_v;
  logic [3:0] valid_v, lock_v, refill_v;
  logic [7:0] data_v [NUM_REQ];

  // Reference model: cycles until idle, last grant, lock owner, output byte
  int         m_wait, m_grant, m_lock;
  logic [7:0] m_txdata;

  // Observations of the most recent cycle
  logic       obs_start, obs_busy;
  logic [1:0] obs_grant;
  logic [7:0] obs_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait   = 0;
    m_grant  = NUM_REQ - 1;
    m_txdata = 8'h00;
    m_lock   = -1;
  endtask

  function automatic int model_winner();
    if (!rst_n_v || m_wait != 0) return -1;
`ifdef UART_ARB_LOCK_EN
    if (m_lock >= 0 && lock_v[m_lock]) return valid_v[m_lock] ? m_lock : -1;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (m_grant + k) % NUM_REQ;
      if (valid_v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic cycle();
    int         w;
    logic [3:0] exp_ready;
    @(negedge Clock);
    Reset_n       = rst_n_v;
    bus.req_valid = valid_v;
    bus.req_lock  = lock_v;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = data_v[i];
    #1;
    w         = model_winner();
    exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
    obs_start = bus.tx_start;
    obs_busy  = bus.busy;
    obs_grant = bus.grant_id;
    obs_data  = bus.tx_data;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("tx_start",  32'(bus.tx_start),  32'(m_wait == BUSY_CYCLES));
    chk("busy",      32'(bus.busy),      32'(m_wait != 0));
    chk("tx_data",   32'(bus.tx_data),   32'(m_txdata));
    chk("grant_id",  32'(bus.grant_id),  32'(m_grant));
    @(posedge Clock);
    cyc++;
    if (!rst_n_v) begin
      model_reset();
    end else if (m_wait != 0) begin
      m_wait--;
    end else begin
`ifdef UART_ARB_LOCK_EN
      if (m_lock >= 0 && !lock_v[m_lock]) m_lock = -1;
`endif
      if (w >= 0) begin
        m_wait   = BUSY_CYCLES;
        m_grant  = w;
        m_txdata = data_v[w];
`ifdef UART_ARB_LOCK_EN
        m_lock   = lock_v[w] ? w : -1;
`endif
        if (refill_v[w]) data_v[w] = 8'($urandom);
        else             valid_v[w] = 1'b0;
      end
    end
  endtask

  task automatic wait_start(output int g);
    g = -1;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (obs_start) begin
        g = int'(obs_grant);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n_v  = 1'b0;
    valid_v  = '0;
    lock_v   = '0;
    refill_v = '0;
    repeat (2) cycle();
    rst_n_v = 1'b1;
  endtask

  initial begin
    int g, busy_cnt, got, last;
    int b_order [5];
    int d_exp [4];
    b_order = '{0, 1, 2, 3, 0};
`ifdef UART_ARB_LOCK_EN
    d_exp = '{1, 1, 1, 2};
`else
    d_exp = '{1, 2, 1, 2};
`endif

    rst_n_v  = 1'b0;
    valid_v  = '0;
    lock_v   = '0;
    refill_v = '0;
    for (int i = 0; i < NUM_REQ; i++) data_v[i] = 8'h00;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_data  = '0;
    model_reset();
    repeat (2) @(posedge Clock);
    cycle();
    cycle();

    // Single requester 0, byte 0x54: acceptance, start, busy length
    rst_n_v   = 1'b1;
    valid_v   = 4'b0001;
    data_v[0] = 8'h54;
    cycle();
    busy_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (n == 0) begin
        chk("a_tx_start", 32'(obs_start), 32'd1);
        chk("a_tx_data",  32'(obs_data),  32'h54);
      end
      if (!obs_busy) break;
      busy_cnt++;
    end
    chk("a_busy_len", 32'(busy_cnt), 32'(BUSY_CYCLES));

    // All four continuously valid: order and start spacing
    do_reset();
    valid_v  = 4'b1111;
    refill_v = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) data_v[i] = 8'($urandom);
    got  = 0;
    last = -1;
    for (int n = 0; n < 700 && got < 5; n++) begin
      cycle();
      if (obs_start) begin
        chk("b_grant", 32'(obs_grant), 32'(b_order[got]));
        if (last >= 0) chk("b_spacing", 32'(cyc - last), 32'(SPACING));
        last = cyc;
        got++;
      end
    end
    chk("b_count", 32'(got), 32'd5);

    // Wrap-around: grant 1, then only 2, then 0 and 3
    do_reset();
    valid_v = 4'b0010;
    wait_start(g);
    chk("c_first", 32'(g), 32'd1);
    valid_v = 4'b0100;
    wait_start(g);
    chk("c_only2", 32'(g), 32'd2);
    valid_v = 4'b1001;
    wait_start(g);
    chk("c_wrap3", 32'(g), 32'd3);
    wait_start(g);
    chk("c_wrap0", 32'(g), 32'd0);

    // Lock on requester 1 against requester 2
    do_reset();
    valid_v  = 4'b0110;
    refill_v = 4'b0110;
    lock_v   = 4'b0010;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) lock_v = 4'b0000;
      wait_start(g);
      chk("d_lock_grant", 32'(g), 32'(d_exp[j]));
    end

    // Reset in the middle of WAIT
    do_reset();
    valid_v = 4'b0001;
    wait_start(g);
    chk("e_first", 32'(g), 32'd0);
    repeat (50) cycle();
    rst_n_v = 1'b0;
    cycle();
    rst_n_v  = 1'b1;
    valid_v  = 4'b1111;
    refill_v = 4'b0000;
    cycle();
    chk("e_busy",  32'(obs_busy),  32'd0);
    chk("e_start", 32'(obs_start), 32'd0);
    chk("e_grant", 32'(obs_grant), 32'd3);
    wait_start(g);
    chk("e_after", 32'(g), 32'd0);

    // Randomized traffic, lock toggling and occasional reset
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid_v[i] && $urandom_range(0, 3) == 0) begin
          valid_v[i] = 1'b1;
          data_v[i]  = 8'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) lock_v = 4'($urandom);
      refill_v = 4'($urandom);
      rst_n_v  = ($urandom_range(0, 999) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
